// File: rtl/uart_rxd.sv
// 8N1 asynchronous serial receiver with 16x oversampling and a level ready/ack handshake.
// Sticky overrun and framing-error flags; data holds the last good byte.
module uart_rxd #(
    parameter int unsigned DIVISOR = 13,
    parameter int unsigned DIVBITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       ack,
    output logic [7:0] data,
    output logic       rdy,
    output logic       ovr,
    output logic       ferr,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        WAITHI = 3'd4
    } state_e;

    localparam logic [DIVBITS-1:0] PRE_MAX = DIVBITS'(DIVISOR - 1);

    state_e             state_q, state_d;
    logic               sync1_q, rs_q, rs_prev_q;
    logic [1:0]         warm_q, warm_d;
    logic [DIVBITS-1:0] pre_q, pre_d;
    logic [3:0]         sub_q, sub_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               rdy_q, rdy_d;
    logic               ovr_q, ovr_d;
    logic               ferr_q, ferr_d;

    logic tick;
    logic fall;
    logic line_valid;
    logic start_edge;
    logic mid_start;
    logic bit_sample;
    logic last_bit;
    logic stop_sample;
    logic stop_good;
    logic stop_bad;

    // NOTE: every flop uses non-blocking assignment so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
            warm_q    <= 2'b00;
        end else begin
            sync1_q   <= rxd;
            rs_q      <= sync1_q;
            rs_prev_q <= rs_q;
            warm_q    <= warm_d;
        end
    end

    // The synchronizer resets high, so rs only reflects the real line once warm_q[1] is set;
    // this keeps a line held low through reset from looking like an idle-then-start sequence.
    assign warm_d     = {warm_q[0], 1'b1};
    assign line_valid = warm_q[1];

    assign tick        = (pre_q == PRE_MAX);
    assign fall        = !rs_q && rs_prev_q;
    assign start_edge  = (state_q == IDLE) && fall;
    assign mid_start   = (state_q == START) && tick && (sub_q == 4'd7);
    assign bit_sample  = (state_q == DATA) && tick && (sub_q == 4'd15);
    assign last_bit    = bit_sample && (bit_idx_q == 3'd7);
    assign stop_sample = (state_q == STOP) && tick && (sub_q == 4'd15);
    assign stop_good   = stop_sample && rs_q;
    assign stop_bad    = stop_sample && !rs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAITHI;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fall) state_d = START;
            START:   if (mid_start) state_d = rs_q ? IDLE : DATA;
            DATA:    if (last_bit) state_d = STOP;
            STOP:    if (stop_sample) state_d = rs_q ? IDLE : WAITHI;
            WAITHI:  if (rs_q && line_valid) state_d = IDLE;
            default: state_d = WAITHI;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // Timing and datapath next-state; set of a flag always wins over the ack clear.
    always_comb begin
        pre_d     = pre_q + DIVBITS'(1);
        sub_d     = sub_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        rdy_d     = rdy_q;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;

        if (start_edge || tick) pre_d = '0;

        if (start_edge || mid_start) begin
            sub_d = 4'd0;
        end else if (tick) begin
            sub_d = sub_q + 4'd1;
        end

        if (mid_start) begin
            bit_idx_d = 3'd0;
        end else if (bit_sample) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end

        if (bit_sample) shift_d = {rs_q, shift_q[7:1]};

        if (ack) begin
            rdy_d  = 1'b0;
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end

        if (stop_good) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            if (rdy_q && !ack) ovr_d = 1'b1;
        end

        if (stop_bad) ferr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= '0;
            sub_q     <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            rdy_q     <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            sub_q     <= sub_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data = data_q;
    assign rdy  = rdy_q;
    assign ovr  = ovr_q;
    assign ferr = ferr_q;

endmodule

// File: tb/tb_uart_rxd.sv
// Directed bench for uart_rxd: frames driven at 208 clk per bit, outputs sampled on the falling clock edge.
module tb_uart_rxd;

    localparam int BIT_CLK = 208;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       ack;
    logic [7:0] data;
    logic       rdy;
    logic       ovr;
    logic       ferr;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rxd #(.DIVISOR(13), .DIVBITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .ack   (ack),
        .data  (data),
        .rdy   (rdy),
        .ovr   (ovr),
        .ferr  (ferr),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (BIT_CLK) @(posedge clk);
        end
        #1 rxd = stop;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int lat;
    int busy_cnt;

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        ack   = 1'b0;
        repeat (4) @(posedge clk);
        sample();
        check("rst_data", 32'(data), 32'h00);
        check("rst_rdy",  32'(rdy),  32'd0);
        check("rst_ovr",  32'(ovr),  32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(6);
        sample();
        check("idle_busy", 32'(busy), 32'd0);

        // Frame 0x41 with rdy latency measured from the driven falling edge.
        lat = 0;
        fork
            send_frame(8'h41, 1'b1);
            begin
                @(posedge clk);
                for (int i = 1; i <= 2500; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (rdy) begin
                        lat = i;
                        break;
                    end
                end
            end
        join
        if (!(lat >= 1978 && lat <= 1980)) $display("rdy latency observed: %0d clk", lat);
        check("lat_window", 32'(lat >= 1978 && lat <= 1980), 32'd1);
        sample();
        check("f41_data", 32'(data), 32'h41);
        check("f41_rdy",  32'(rdy),  32'd1);
        check("f41_ovr",  32'(ovr),  32'd0);
        check("f41_ferr", 32'(ferr), 32'd0);
        check("f41_busy", 32'(busy), 32'd0);
        pulse_ack();
        sample();
        check("f41_ack_rdy", 32'(rdy), 32'd0);

        // 60-clk low glitch: rejected at mid-start after about 104 clk of busy.
        idle(50);
        busy_cnt = 0;
        #0 rxd = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (i == 59) rxd = 1'b1;
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        if (!(busy_cnt >= 100 && busy_cnt <= 108)) $display("glitch busy cycles: %0d", busy_cnt);
        check("glitch_busy_len", 32'(busy_cnt >= 100 && busy_cnt <= 108), 32'd1);
        check("glitch_rdy",  32'(rdy),  32'd0);
        check("glitch_ferr", 32'(ferr), 32'd0);
        check("glitch_ovr",  32'(ovr),  32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        idle(20);
        send_frame(8'h5A, 1'b1);
        sample();
        check("f5a_data", 32'(data), 32'h5A);
        check("f5a_rdy",  32'(rdy),  32'd1);
        pulse_ack();
        idle(20);

        // 0x55 with a low stop bit and a held break.
        send_frame(8'h55, 1'b0);
        idle(790);
        sample();
        check("brk_ferr", 32'(ferr), 32'd1);
        check("brk_rdy",  32'(rdy),  32'd0);
        check("brk_data", 32'(data), 32'h5A);
        check("brk_busy", 32'(busy), 32'd1);
        rxd = 1'b1;
        idle(5);
        sample();
        check("brk_end_busy", 32'(busy), 32'd0);
        idle(20);
        send_frame(8'hA5, 1'b1);
        sample();
        check("fa5_data", 32'(data), 32'hA5);
        check("fa5_rdy",  32'(rdy),  32'd1);
        check("fa5_ferr", 32'(ferr), 32'd1);
        pulse_ack();
        sample();
        check("fa5_ack_ferr", 32'(ferr), 32'd0);
        check("fa5_ack_rdy",  32'(rdy),  32'd0);
        idle(20);

        // Back-to-back 0x11, 0x22 without ack.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        sample();
        check("b2b_data", 32'(data), 32'h22);
        check("b2b_rdy",  32'(rdy),  32'd1);
        check("b2b_ovr",  32'(ovr),  32'd1);
        pulse_ack();
        sample();
        check("b2b_ack_rdy", 32'(rdy), 32'd0);
        check("b2b_ack_ovr", 32'(ovr), 32'd0);
        idle(20);

        // 0x33 left pending, then 0x44 with ack on the exact update cycle.
        send_frame(8'h33, 1'b1);
        sample();
        check("f33_data", 32'(data), 32'h33);
        check("f33_ovr",  32'(ovr),  32'd0);
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (1979) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        sample();
        check("coin_data", 32'(data), 32'h44);
        check("coin_rdy",  32'(rdy),  32'd1);
        check("coin_ovr",  32'(ovr),  32'd0);
        idle(20);

        // Reset in the middle of 0x77 with the line held low afterwards.
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3 * BIT_CLK) @(posedge clk);
        #1 rxd = 1'b0;
        sample();
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(3);
        sample();
        check("mrst_data", 32'(data), 32'h00);
        check("mrst_rdy",  32'(rdy),  32'd0);
        check("mrst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(500);
        sample();
        check("low_busy", 32'(busy), 32'd1);
        check("low_rdy",  32'(rdy),  32'd0);
        check("low_ferr", 32'(ferr), 32'd0);
        rxd = 1'b1;
        idle(BIT_CLK);
        send_frame(8'h0F, 1'b1);
        sample();
        check("f0f_data", 32'(data), 32'h0F);
        check("f0f_rdy",  32'(rdy),  32'd1);
        check("f0f_ferr", 32'(ferr), 32'd0);
        check("f0f_ovr",  32'(ovr),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
